hilo_mult_seq: RTL and testbench

Iterative shift-add multiplier that owns the HI/LO register pair for the pipeline's EX stage. It executes MULT/MULTU one multiplier bit per cycle and writes the 64-bit product into HI/LO. It interlocks MFHI/MFLO, and any new multiply issued while it is busy, by raising a stall request toward fetch. It sits beside the ALU and is driven by the control unit's `enhilo_EX` and `regsel_EX` decode.

---
 rtl/hilo_mult_seq_if.sv | 27 ++
 rtl/hilo_mult_seq.sv | 133 +++++++++++++
 tb/tb_hilo_mult_seq.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_mult_seq_if.sv
// hilo_mult_seq_if: issue/readback bundle between the EX-stage control
// decode (master) and the iterative HI/LO multiplier (slave).
interface hilo_mult_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             rd_hi_req;
   logic             rd_lo_req;
   logic             busy;
   logic             done;
   logic             stall_FETCH;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, is_signed, op_a, op_b, rd_hi_req, rd_lo_req,
      input  busy, done, stall_FETCH, hi, lo
   );

   modport slave (
      input  start, is_signed, op_a, op_b, rd_hi_req, rd_lo_req,
      output busy, done, stall_FETCH, hi, lo
   );
endinterface

// File: rtl/hilo_mult_seq.sv
// hilo_mult_seq: iterative shift-add MULT/MULTU unit owning HI/LO.
// Multiplies magnitudes one multiplier bit per cycle, then applies the
// sign in a single FIX cycle. Stalls fetch for MFHI/MFLO or a new multiply
// while busy.
// Optional feature macro: MULT_EARLY_EXIT_EN -- leave RUN as soon as the
// remaining multiplier bits are all zero, aligning the product in one shot.
module hilo_mult_seq #(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst,
   hilo_mult_seq_if.slave bus
);
   localparam int PW = 2*WIDTH + 1;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [PW-1:0]      prod_q,  prod_d;
   logic [CW-1:0]      cnt_q,   cnt_d;
   logic               neg_q,   neg_d;
   logic               busy_q,  busy_d;
   logic               done_q,  done_d;
   logic [WIDTH-1:0]   hi_q,    hi_d;
   logic [WIDTH-1:0]   lo_q,    lo_d;
   logic [PW-1:0]      run_acc;
   logic [2*WIDTH-1:0] result;

   // Two's-complement magnitude; 0x80..0 maps to 2^(WIDTH-1) unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             sgn);
      return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   // Restore the product sign across the full 2W-bit result.
   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                     input logic               n);
      return n ? (~p + 1'b1) : p;
   endfunction

`ifdef MULT_EARLY_EXIT_EN
   logic [WIDTH-1:0] rest_mask;
   logic [CW-1:0]    rem_cnt;
   // Multiplier bits still unconsumed after this cycle's shift, and how far
   // the product must still move to reach its final alignment.
   assign rest_mask = {WIDTH{1'b1}} >> (cnt_q + 1'b1);
   assign rem_cnt   = CW'(WIDTH - 1) - cnt_q;
`endif

   assign result = apply_sign(prod_q[2*WIDTH-1:0], neg_q);

   // Next-state, datapath step and output-register inputs.
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      run_acc = prod_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               mcand_d = magnitude(bus.op_a, bus.is_signed);
               prod_d  = {{(WIDTH+1){1'b0}}, magnitude(bus.op_b, bus.is_signed)};
               neg_d   = bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (prod_q[0])
               run_acc[2*WIDTH:WIDTH] = prod_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
            run_acc = run_acc >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
`ifdef MULT_EARLY_EXIT_EN
            else if ((run_acc[WIDTH-1:0] & rest_mask) == '0) begin
               run_acc = run_acc >> rem_cnt;
               state_d = S_FIX;
            end
`endif
            prod_d = run_acc;
         end
         S_FIX: begin
            hi_d    = result[2*WIDTH-1:WIDTH];
            lo_d    = result[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and HI/LO registers; reset aborts any multiply without a write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.stall_FETCH = busy_q & (bus.start | bus.rd_hi_req | bus.rd_lo_req);

endmodule

// File: tb/tb_hilo_mult_seq.sv
// tb_hilo_mult_seq: self-checking bench for hilo_mult_seq against a plain
// 64-bit arithmetic reference and a latency model derived from operand bits.
module tb_hilo_mult_seq;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   hilo_mult_seq_if #(.WIDTH(32)) bus ();

   hilo_mult_seq #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference product from ordinary 64-bit signed/unsigned multiplication.
   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input bit s);
      logic signed [63:0] sa, sb;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      if (s) return sa * sb;
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Cycles from the start edge to the done cycle.
   function automatic int ref_lat(input logic [31:0] b, input bit s);
`ifdef MULT_EARLY_EXIT_EN
      logic [31:0] m;
      int n;
      m = (s && b[31]) ? (~b + 32'd1) : b;
      n = 0;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      if (n < 1) n = 1;
      return n + 2;
`else
      return 34;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one multiply and follow it to done; gathers observations only.
   task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input bit s,
                          output logic [31:0] h, output logic [31:0] l,
                          output int lat, output int busy_cnt, output bit held);
      logic [31:0] h0, l0;
      h0 = bus.hi;
      l0 = bus.lo;
      held = 1'b1;
      bus.start = 1'b1; bus.is_signed = s; bus.op_a = a; bus.op_b = b;
      tick();
      bus.start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (!bus.done && lat < 200) begin
         if (bus.busy) busy_cnt++;
         if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
         tick();
         lat++;
      end
      h = bus.hi;
      l = bus.lo;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      bus.start = 1'b1; bus.op_a = 32'd3; bus.op_b = 32'd4; bus.rd_hi_req = 1'b1;
      tick();
      rst = 1'b0;
      bus.start = 1'b0;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", bus.busy, bus.done);
      end
      n_tests++;
      if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_hilo: hi=%h lo=%h, required 0 0", bus.hi, bus.lo);
      end
      n_tests++;
      if (bus.stall_FETCH !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stall: stall=%b, required 0", bus.stall_FETCH);
      end
      tick();
      bus.rd_hi_req = 1'b0;
      n_tests++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_start_dropped: busy=%b, required 0", bus.busy);
      end
   endtask

   task automatic test_directed();
      logic [31:0] av [4] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'h00010000};
      logic [31:0] bv [4] = '{32'hFFFFFFFF, 32'h00000005, 32'h80000000, 32'h00010001};
      bit          sv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [63:0] ev [4] = '{64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFF1,
                              64'h40000000_00000000, 64'h00000001_00010000};
      logic [31:0] h, l;
      int lat, bc;
      bit held;
      for (int i = 0; i < 4; i++) begin
         do_mult(av[i], bv[i], sv[i], h, l, lat, bc, held);
         n_tests++;
         if ({h, l} !== ev[i]) begin
            n_fail++;
            $display("FAIL directed_prod[%0d]: got %h_%h, required %h", i, h, l, ev[i]);
         end
         n_tests++;
         if (lat !== ref_lat(bv[i], sv[i]) || bc !== lat - 1) begin
            n_fail++;
            $display("FAIL directed_lat[%0d]: done at %0d busy %0d, required done %0d busy %0d",
                     i, lat, bc, ref_lat(bv[i], sv[i]), ref_lat(bv[i], sv[i]) - 1);
         end
         tick();
      end
   endtask

   task automatic test_early_exit();
      logic [31:0] h, l;
      int lat, bc, want;
      bit held;
`ifdef MULT_EARLY_EXIT_EN
      want = 3;
`else
      want = 34;
`endif
      do_mult(32'd5, 32'd1, 1'b0, h, l, lat, bc, held);
      n_tests++;
      if (h !== 32'd0 || l !== 32'd5 || lat !== want) begin
         n_fail++;
         $display("FAIL exit_5x1: hi=%h lo=%h lat=%0d, required 0 5 lat=%0d", h, l, lat, want);
      end
      do_mult(32'd5, 32'd0, 1'b0, h, l, lat, bc, held);
      n_tests++;
      if (h !== 32'd0 || l !== 32'd0 || lat !== want) begin
         n_fail++;
         $display("FAIL exit_5x0: hi=%h lo=%h lat=%0d, required 0 0 lat=%0d", h, l, lat, want);
      end
      tick();
   endtask

   task automatic test_stall_interlock();
      int lat, pulse_at, bad;
      lat = ref_lat(32'd6, 1'b0);
      pulse_at = (lat > 8) ? 5 : 2;
      bad = 0;
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd7; bus.op_b = 32'd6;
      tick();
      bus.start = 1'b0;
      bus.rd_lo_req = 1'b1;
      for (int c = 1; c < lat; c++) begin
         if (bus.stall_FETCH !== 1'b1) bad++;
         if (c == pulse_at) begin
            bus.start = 1'b1; bus.op_a = 32'd100; bus.op_b = 32'd3;
         end else begin
            bus.start = 1'b0;
         end
         tick();
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL stall_busy: %0d cycles low, required 0", bad);
      end
      n_tests++;
      if (bus.done !== 1'b1 || bus.stall_FETCH !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_release: done=%b stall=%b, required 1 0", bus.done, bus.stall_FETCH);
      end
      n_tests++;
      if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin
         n_fail++;
         $display("FAIL stall_value: hi=%h lo=%h, required 0 2a", bus.hi, bus.lo);
      end
      bus.rd_lo_req = 1'b0;
      tick();
      n_tests++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_ignored_start: busy=%b, required 0", bus.busy);
      end
   endtask

   task automatic test_idle_read();
      bus.rd_hi_req = 1'b1;
      bus.rd_lo_req = 1'b1;
      #1;
      n_tests++;
      if (bus.stall_FETCH !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_read_stall: stall=%b, required 0", bus.stall_FETCH);
      end
      tick();
      bus.rd_hi_req = 1'b0;
      bus.rd_lo_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a, b, h, l;
      bit s, held;
      int lat, bc;
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if (i % 5 == 0) b = -b;
         s = $urandom_range(0, 1);
         do_mult(a, b, s, h, l, lat, bc, held);
         n_tests++;
         if ({h, l} !== ref_prod(a, b, s) || !held) begin
            n_fail++;
            $display("FAIL rand_prod[%0d]: %h*%h s=%0d got %h_%h held=%0d, required %h held=1",
                     i, a, b, s, h, l, held, ref_prod(a, b, s));
         end
         n_tests++;
         if (lat !== ref_lat(b, s) || bc !== lat - 1) begin
            n_fail++;
            $display("FAIL rand_lat[%0d]: done %0d busy %0d, required done %0d busy %0d",
                     i, lat, bc, ref_lat(b, s), ref_lat(b, s) - 1);
         end
      end
      tick();
   endtask

   task automatic test_abort();
      logic [31:0] h, l;
      int lat, bc, rst_at, pulses;
      bit held;
      do_mult(32'h00010000, 32'h00010001, 1'b0, h, l, lat, bc, held);
      n_tests++;
      if (h !== 32'h1 || l !== 32'h00010000) begin
         n_fail++;
         $display("FAIL abort_preload: hi=%h lo=%h, required 1 00010000", h, l);
      end
      tick();
      rst_at = (ref_lat(32'd9, 1'b0) > 12) ? 10 : 3;
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd9; bus.op_b = 32'd9;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < rst_at; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_state: busy=%b hi=%h lo=%h done=%b, required 0 0 0 0",
                  bus.busy, bus.hi, bus.lo, bus.done);
      end
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
         tick();
      end
      n_tests++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: %0d active cycles, required 0", pulses);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.is_signed = 1'b0; bus.op_a = '0; bus.op_b = '0;
      bus.rd_hi_req = 1'b0; bus.rd_lo_req = 1'b0;
      #2;
      test_reset();
      test_directed();
      test_early_exit();
      test_stall_interlock();
      test_idle_read();
      test_back_to_back();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
